// File: rtl/mult_sweep_checker.sv
// Exhaustive stimulus/check stage for a combinational WIDTH x WIDTH multiplier candidate.
// Define STOP_ON_FAIL_EN to end the sweep at the first mismatching vector.
module mult_sweep_checker #(
    parameter int WIDTH  = 2,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [WIDTH-1:0]     mult_a,
    output logic [WIDTH-1:0]     mult_b,
    input  logic [2*WIDTH-1:0]   mult_p,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH:0]     err_count,
    output logic                 fail_valid,
    output logic [WIDTH-1:0]     fail_a,
    output logic [WIDTH-1:0]     fail_b,
    output logic [2*WIDTH-1:0]   fail_p
);

    localparam int PW = 2 * WIDTH;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [3:0]    SETTLE_LD = 4'(SETTLE);
    localparam logic [1:0]    S_AFTER   = (SETTLE == 0) ? S_CHECK : S_WAIT;
    localparam logic [PW-1:0] IDX_LAST  = {PW{1'b1}};
    localparam logic [PW-1:0] IDX_ONE   = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW:0]   ERR_ONE   = {{PW{1'b0}}, 1'b1};

    logic [1:0]    state_r;
    logic [PW-1:0] idx_r;
    logic [3:0]    settle_cnt_r;
    logic [PW-1:0] golden_s;
    logic          mismatch_s;
    logic          last_s;
    logic [PW:0]   err_inc_s;

    // Reference product, zero-extended so it can never truncate.
    function automatic logic [PW-1:0] golden_product(input logic [WIDTH-1:0] a,
                                                     input logic [WIDTH-1:0] b);
        return PW'(a) * PW'(b);
    endfunction

    // Operands are the two halves of the registered vector index.
    assign mult_a = idx_r[PW-1:WIDTH];
    assign mult_b = idx_r[WIDTH-1:0];

    // Compare the candidate against the golden product and decide when the sweep ends.
    always_comb begin
        golden_s   = golden_product(mult_a, mult_b);
        mismatch_s = (mult_p != golden_s);
        if (&err_count) begin
            err_inc_s = err_count;
        end else begin
            err_inc_s = err_count + ERR_ONE;
        end
`ifdef STOP_ON_FAIL_EN
        last_s = (idx_r == IDX_LAST) || mismatch_s;
`else
        last_s = (idx_r == IDX_LAST);
`endif
    end

    // Sweep sequencer and result capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= S_IDLE;
            idx_r        <= '0;
            settle_cnt_r <= 4'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            err_count    <= '0;
            fail_valid   <= 1'b0;
            fail_a       <= '0;
            fail_b       <= '0;
            fail_p       <= '0;
        end else begin
            case (state_r)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_r      <= S_AFTER;
                        idx_r        <= '0;
                        settle_cnt_r <= SETTLE_LD;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        pass         <= 1'b0;
                        err_count    <= '0;
                        fail_valid   <= 1'b0;
                        fail_a       <= '0;
                        fail_b       <= '0;
                        fail_p       <= '0;
                    end
                end
                S_WAIT: begin
                    settle_cnt_r <= settle_cnt_r - 4'd1;
                    if (settle_cnt_r <= 4'd1) begin
                        state_r <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (mismatch_s) begin
                        err_count <= err_inc_s;
                        if (!fail_valid) begin
                            fail_valid <= 1'b1;
                            fail_a     <= mult_a;
                            fail_b     <= mult_b;
                            fail_p     <= mult_p;
                        end
                    end
                    if (last_s) begin
                        state_r <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= !mismatch_s && (err_count == '0);
                    end else begin
                        state_r      <= S_AFTER;
                        idx_r        <= idx_r + IDX_ONE;
                        settle_cnt_r <= SETTLE_LD;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_sweep_checker.sv
// Directed bench for mult_sweep_checker: SETTLE=1 and SETTLE=0 instances driven by a multiplier model.
module tb_mult_sweep_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start0, start1;
    logic       fault;
    logic [1:0] a0, b0, a1, b1;
    logic [3:0] p0, p1, prod0;
    logic       busy0, done0, pass0, fv0;
    logic       busy1, done1, pass1, fv1;
    logic [4:0] err0, err1;
    logic [1:0] fa0, fb0, fa1, fb1;
    logic [3:0] fp0, fp1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Candidate models: optional P[0] stuck-at-0 on instance 0, ideal on instance 1.
    assign prod0 = {2'b00, a0} * {2'b00, b0};
    assign p0    = fault ? {prod0[3:1], 1'b0} : prod0;
    assign p1    = {2'b00, a1} * {2'b00, b1};

    mult_sweep_checker #(.WIDTH(2), .SETTLE(1)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .mult_a(a0), .mult_b(b0), .mult_p(p0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .fail_valid(fv0),
        .fail_a(fa0), .fail_b(fb0), .fail_p(fp0)
    );

    mult_sweep_checker #(.WIDTH(2), .SETTLE(0)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .mult_a(a1), .mult_b(b1), .mult_p(p1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_valid(fv1),
        .fail_a(fa1), .fail_b(fb1), .fail_p(fp1)
    );

    task automatic test_reset;
        rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; fault = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if ({busy0, done0, pass0, fv0} !== 4'b0000) begin
            miscompares++; $display("FAIL reset_flags0: got %b expected 0000", {busy0, done0, pass0, fv0});
        end
        vectors++;
        if ({err0, a0, b0, fa0, fb0, fp0} !== 17'd0) begin
            miscompares++; $display("FAIL reset_data0: got %h expected 0", {err0, a0, b0, fa0, fb0, fp0});
        end
        vectors++;
        if ({busy1, done1, pass1, fv1, err1} !== 9'd0) begin
            miscompares++; $display("FAIL reset_u1: got %h expected 0", {busy1, done1, pass1, fv1, err1});
        end
    endtask

    task automatic test_ideal;
        int n;
        fault = 1'b0;
        start0 = 1'b1; @(posedge clk); #1 start0 = 1'b0;
        vectors++;
        if (busy0 !== 1'b1 || done0 !== 1'b0) begin
            miscompares++; $display("FAIL ideal_busy: got busy=%b done=%b expected busy=1 done=0", busy0, done0);
        end
        n = 0;
        while (!done0 && n < 200) begin
            @(posedge clk); #1 n++;
            if (n == 2) begin
                vectors++;
                if (a0 !== 2'd0 || b0 !== 2'd1) begin
                    miscompares++; $display("FAIL ideal_operands: got a=%0d b=%0d expected a=0 b=1", a0, b0);
                end
            end
        end
        vectors++;
        if (n !== 32) begin
            miscompares++; $display("FAIL ideal_latency: got %0d cycles expected 32", n);
        end
        vectors++;
        if (err0 !== 5'd0 || pass0 !== 1'b1 || fv0 !== 1'b0 || busy0 !== 1'b0) begin
            miscompares++; $display("FAIL ideal_result: got err=%0d pass=%b fv=%b busy=%b expected 0 1 0 0", err0, pass0, fv0, busy0);
        end
        vectors++;
        if (a0 !== 2'd3 || b0 !== 2'd3) begin
            miscompares++; $display("FAIL ideal_hold_operands: got a=%0d b=%0d expected 3 3", a0, b0);
        end
    endtask

    task automatic test_fault;
        int n;
        int exp_n;
        logic [4:0] exp_err;
`ifdef STOP_ON_FAIL_EN
        exp_n = 12; exp_err = 5'd1;
`else
        exp_n = 32; exp_err = 5'd4;
`endif
        fault = 1'b1;
        start0 = 1'b1; @(posedge clk); #1 start0 = 1'b0;
        n = 0;
        while (!done0 && n < 200) begin
            @(posedge clk); #1 n++;
        end
        vectors++;
        if (n !== exp_n) begin
            miscompares++; $display("FAIL fault_latency: got %0d cycles expected %0d", n, exp_n);
        end
        vectors++;
        if (err0 !== exp_err) begin
            miscompares++; $display("FAIL fault_err_count: got %0d expected %0d", err0, exp_err);
        end
        vectors++;
        if (fv0 !== 1'b1 || fa0 !== 2'd1 || fb0 !== 2'd1 || fp0 !== 4'd0) begin
            miscompares++; $display("FAIL fault_capture: got fv=%b a=%0d b=%0d p=%0d expected 1 1 1 0", fv0, fa0, fb0, fp0);
        end
        vectors++;
        if (pass0 !== 1'b0 || busy0 !== 1'b0) begin
            miscompares++; $display("FAIL fault_pass: got pass=%b busy=%b expected 0 0", pass0, busy0);
        end
    endtask

    task automatic test_restart_after_fail;
        int n;
        fault = 1'b0;
        start0 = 1'b1; @(posedge clk); #1 start0 = 1'b0;
        vectors++;
        if (err0 !== 5'd0 || fv0 !== 1'b0 || done0 !== 1'b0 || busy0 !== 1'b1) begin
            miscompares++; $display("FAIL restart_clear: got err=%0d fv=%b done=%b busy=%b expected 0 0 0 1", err0, fv0, done0, busy0);
        end
        n = 0;
        while (!done0 && n < 200) begin
            @(posedge clk); #1 n++;
        end
        vectors++;
        if (n !== 32 || pass0 !== 1'b1) begin
            miscompares++; $display("FAIL restart_result: got cycles=%0d pass=%b expected 32 1", n, pass0);
        end
    endtask

    task automatic test_start_held;
        int n;
        start0 = 1'b1; @(posedge clk); #1;
        n = 0;
        while (!done0 && n < 200) begin
            start0 = (n < 10);
            @(posedge clk); #1 n++;
        end
        start0 = 1'b0;
        vectors++;
        if (n !== 32) begin
            miscompares++; $display("FAIL held_latency: got %0d cycles expected 32", n);
        end
        vectors++;
        if (err0 !== 5'd0 || pass0 !== 1'b1 || fv0 !== 1'b0) begin
            miscompares++; $display("FAIL held_result: got err=%0d pass=%b fv=%b expected 0 1 0", err0, pass0, fv0);
        end
    endtask

    task automatic test_reset_mid;
        int n;
        start0 = 1'b1; @(posedge clk); #1 start0 = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        vectors++;
        if (a0 !== 2'd1 || b0 !== 2'd3 || busy0 !== 1'b1) begin
            miscompares++; $display("FAIL mid_index: got a=%0d b=%0d busy=%b expected 1 3 1", a0, b0, busy0);
        end
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        vectors++;
        if ({busy0, done0, pass0, fv0, err0, a0, b0, fa0, fb0, fp0} !== 21'd0) begin
            miscompares++; $display("FAIL mid_reset: got %h expected 0", {busy0, done0, pass0, fv0, err0, a0, b0, fa0, fb0, fp0});
        end
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (busy0 !== 1'b0 || a0 !== 2'd0 || b0 !== 2'd0) begin
            miscompares++; $display("FAIL mid_idle: got busy=%b a=%0d b=%0d expected 0 0 0", busy0, a0, b0);
        end
        start0 = 1'b1; @(posedge clk); #1 start0 = 1'b0;
        n = 0;
        while (!done0 && n < 200) begin
            @(posedge clk); #1 n++;
        end
        vectors++;
        if (n !== 32 || pass0 !== 1'b1) begin
            miscompares++; $display("FAIL mid_resweep: got cycles=%0d pass=%b expected 32 1", n, pass0);
        end
    endtask

    task automatic test_settle0;
        int n;
        start1 = 1'b1; @(posedge clk); #1 start1 = 1'b0;
        vectors++;
        if (busy1 !== 1'b1) begin
            miscompares++; $display("FAIL s0_busy: got %b expected 1", busy1);
        end
        n = 0;
        while (!done1 && n < 200) begin
            @(posedge clk); #1 n++;
        end
        vectors++;
        if (n !== 16) begin
            miscompares++; $display("FAIL s0_latency: got %0d cycles expected 16", n);
        end
        vectors++;
        if (pass1 !== 1'b1 || err1 !== 5'd0 || a1 !== 2'd3 || b1 !== 2'd3) begin
            miscompares++; $display("FAIL s0_result: got pass=%b err=%0d a=%0d b=%0d expected 1 0 3 3", pass1, err1, a1, b1);
        end
    endtask

    initial begin
        test_reset;
        test_ideal;
        test_fault;
        test_restart_after_fail;
        test_start_held;
        test_reset_mid;
        test_settle0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
